// File: rtl/led_sbox_layer_seq.sv
// Sequencer for one masked LED S-box layer.
// A 3-share 64-bit state is issued one byte per cycle into an external
// 3-share S-box pipeline. The returned bytes are collected into per-share
// staging registers and published on out1..3 together with a one-cycle done.
// Each share has its own datapath. No logic in this block combines two shares.
module led_sbox_layer_seq #(
    parameter int LATENCY = 3,  // S-box pipeline depth, 1..7
    parameter int NBYTES  = 8   // bytes per LED-64 state
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   in1,
    input  logic [8*NBYTES-1:0]   in2,
    input  logic [8*NBYTES-1:0]   in3,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   out1,
    output logic [8*NBYTES-1:0]   out2,
    output logic [8*NBYTES-1:0]   out3,
    output logic [7:0]            sb_in1,
    output logic [7:0]            sb_in2,
    output logic [7:0]            sb_in3,
    output logic                  sb_en,
    input  logic [7:0]            sb_out1,
    input  logic [7:0]            sb_out2,
    input  logic [7:0]            sb_out3
);

    localparam int W   = 8 * NBYTES;
    localparam int NSH = 3;
    localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Issue counter (byte being sent) and capture counter (bytes received).
    logic [2:0] ic_q, ic_d;
    logic [2:0] cc_q, cc_d;

    // Delay line that tracks which pipeline slots hold real bytes.
    logic [LATENCY-1:0]   dl_vld_q, dl_vld_d;
    logic [3*LATENCY-1:0] dl_idx_q, dl_idx_d;

    // Shares flattened so each share lane can take its own slice.
    logic [NSH*W-1:0] in_flat;
    logic [NSH*W-1:0] out_flat;
    logic [NSH*8-1:0] sb_in_flat;
    logic [NSH*8-1:0] sb_out_flat;

    logic       accept;
    logic       run;
    logic       drain;
    logic       cap_vld;
    logic [2:0] cap_idx;
    logic       cap_last;

    assign in_flat     = {in3, in2, in1};
    assign sb_out_flat = {sb_out3, sb_out2, sb_out1};

    assign out1   = out_flat[0*W +: W];
    assign out2   = out_flat[1*W +: W];
    assign out3   = out_flat[2*W +: W];
    assign sb_in1 = sb_in_flat[0*8 +: 8];
    assign sb_in2 = sb_in_flat[1*8 +: 8];
    assign sb_in3 = sb_in_flat[2*8 +: 8];

    assign accept = (state_q == S_IDLE) && start;
    assign run    = (state_q == S_RUN);
    assign drain  = (state_q == S_DRAIN);

    // A byte returning from the pipeline is only meaningful while a layer runs;
    // the index travels with it so each byte lands in the slot it came from.
    assign cap_vld  = dl_vld_q[LATENCY-1] && (run || drain);
    assign cap_idx  = dl_idx_q[3*(LATENCY-1) +: 3];
    assign cap_last = cap_vld && (cc_q == LAST_BYTE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: issue 8 bytes, wait for the 8th result, publish for one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (ic_q == LAST_BYTE) state_d = S_DRAIN;
            S_DRAIN: if (cap_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state; the pipeline runs through RUN and DRAIN
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
        sb_en = (state_q == S_RUN) || (state_q == S_DRAIN);
    end

    // Counter next values: cleared on accept, ic advances per issued byte,
    // cc per captured byte (both 3 bits, wrapping is harmless)
    always_comb begin
        ic_d = ic_q;
        cc_d = cc_q;
        if (accept) begin
            ic_d = 3'd0;
            cc_d = 3'd0;
        end else begin
            if (run) begin
                ic_d = ic_q + 3'd1;
            end
            if (cap_vld) begin
                cc_d = cc_q + 3'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_q <= 3'd0;
            cc_q <= 3'd0;
        end else begin
            ic_q <= ic_d;
            cc_q <= cc_d;
        end
    end

    // Delay line shifts every cycle; a slot is valid only if it was issued in RUN.
    // When sb_en drops the layer is complete, so shifting unconditionally is safe.
    always_comb begin
        dl_vld_d        = dl_vld_q;
        dl_idx_d        = dl_idx_q;
        dl_vld_d[0]     = run;
        dl_idx_d[0 +: 3] = ic_q;
        for (int i = 1; i < LATENCY; i++) begin
            dl_vld_d[i]         = dl_vld_q[i-1];
            dl_idx_d[3*i +: 3]  = dl_idx_q[3*(i-1) +: 3];
        end
    end

    // Delay line registers; clearing them on reset drops any in-flight results
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld_q <= '0;
            dl_idx_q <= '0;
        end else begin
            dl_vld_q <= dl_vld_d;
            dl_idx_q <= dl_idx_d;
        end
    end

    // One independent lane per share: input latch, byte mux, staging, result
    for (genvar gi = 0; gi < NSH; gi++) begin : g_share
        logic [W-1:0] sh_q, sh_d;
        logic [W-1:0] stg_q, stg_d;
        logic [W-1:0] res_q, res_d;
        logic [7:0]   byte_sel;

        // Share register: loaded only when a layer is accepted
        always_comb begin
            sh_d = sh_q;
            if (accept) begin
                sh_d = in_flat[gi*W +: W];
            end
        end

        // Byte sent to the pipeline; forced to zero outside RUN so nothing stale leaks
        always_comb begin
            byte_sel = 8'd0;
            if (run) begin
                byte_sel = sh_q[8*ic_q +: 8];
            end
        end

        // Staging register: returning byte written into its slot
        always_comb begin
            stg_d = stg_q;
            if (cap_vld) begin
                stg_d[8*cap_idx +: 8] = sb_out_flat[gi*8 +: 8];
            end
        end

        // Result register: takes the completed staging value as DONE is entered
        always_comb begin
            res_d = res_q;
            if (cap_last) begin
                res_d = stg_d;
            end
        end

        // Lane registers
        always_ff @(posedge clk) begin
            if (rst) begin
                sh_q  <= '0;
                stg_q <= '0;
                res_q <= '0;
            end else begin
                sh_q  <= sh_d;
                stg_q <= stg_d;
                res_q <= res_d;
            end
        end

        assign sb_in_flat[gi*8 +: 8] = byte_sel;
        assign out_flat[gi*W +: W]   = res_q;
    end

endmodule
